// File: rtl/sram_pipe.sv
// Single-port SRAM model: req/gnt handshake, byte strobes, 1/2-cycle read pipe.
// Optional zero-fill sequence after reset holds off grants until done.
module sram_pipe #(
   parameter int DATA_WIDTH     = 64,
   parameter int NUM_WORDS      = 8,
   parameter int READ_LATENCY   = 1,
   parameter bit CLEAR_ON_RESET = 1'b1,
   localparam int ADDR_WIDTH    = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    req_i,
   input  logic                    we_i,
   input  logic [ADDR_WIDTH-1:0]   addr_i,
   input  logic [DATA_WIDTH-1:0]   wdata_i,
   input  logic [DATA_WIDTH/8-1:0] be_i,
   output logic                    gnt_o,
   output logic                    rvalid_o,
   output logic [DATA_WIDTH-1:0]   rdata_o
);

   localparam int NB = DATA_WIDTH / 8;

   typedef enum logic {
      S_CLEAR,
      S_READY
   } state_e;

   localparam state_e RST_STATE = CLEAR_ON_RESET ? S_CLEAR : S_READY;
   localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(NUM_WORDS - 1);

   state_e                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   clr_addr_q, clr_addr_d;
   logic                    clr_we;
   logic [DATA_WIDTH-1:0]   mem_q [NUM_WORDS];

   logic [31:0]             addr_ext;
   logic                    in_range;
   logic                    wr_acc;
   logic                    rd_acc;
   logic [DATA_WIDTH-1:0]   rd_word;

   logic                    v1_q;
   logic [DATA_WIDTH-1:0]   d1_q;

   always_comb begin
      state_d    = state_q;
      clr_addr_d = clr_addr_q;
      clr_we     = 1'b0;
      gnt_o      = 1'b0;
      unique case (state_q)
         S_CLEAR: begin
            clr_we = 1'b1;
            if (clr_addr_q == LAST) begin
               state_d = S_READY;
            end else begin
               clr_addr_d = clr_addr_q + 1'b1;
            end
         end
         S_READY: gnt_o = 1'b1;
         default: ;
      endcase
      // Reset wins combinationally so nothing is granted or cleared in reset
      if (!rst_ni) begin
         clr_we     = 1'b0;
         gnt_o      = 1'b0;
         state_d    = RST_STATE;
         clr_addr_d = '0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q    <= RST_STATE;
         clr_addr_q <= '0;
      end else begin
         state_q    <= state_d;
         clr_addr_q <= clr_addr_d;
      end
   end

   assign addr_ext = 32'(addr_i);
   assign in_range = addr_ext < 32'(NUM_WORDS);
   assign wr_acc   = req_i & gnt_o & we_i & in_range;
   assign rd_acc   = req_i & gnt_o & ~we_i;
   assign rd_word  = in_range ? mem_q[addr_i] : '0;

   always_ff @(posedge clk_i) begin
      if (clr_we) begin
         mem_q[clr_addr_q] <= '0;
      end else if (wr_acc) begin
         for (int b = 0; b < NB; b++) begin
            if (be_i[b]) begin
               mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         v1_q <= 1'b0;
         d1_q <= '0;
      end else begin
         v1_q <= rd_acc;
         if (rd_acc) begin
            d1_q <= rd_word;
         end
      end
   end

   if (READ_LATENCY == 2) begin : g_lat2
      logic                  v2_q;
      logic [DATA_WIDTH-1:0] d2_q;

      always_ff @(posedge clk_i) begin
         if (!rst_ni) begin
            v2_q <= 1'b0;
            d2_q <= '0;
         end else begin
            v2_q <= v1_q;
            if (v1_q) begin
               d2_q <= d1_q;
            end
         end
      end

      assign rvalid_o = v2_q;
      assign rdata_o  = d2_q;
   end else begin : g_lat1
      assign rvalid_o = v1_q;
      assign rdata_o  = d1_q;
   end

endmodule

// File: tb/tb_sram_pipe.sv
// Bench for sram_pipe: three configurations on shared stimulus,
// each checked every cycle against its own behavioural model.
module tb_sram_pipe;

   logic        clk = 1'b0;
   logic        rst_ni = 1'b0;
   logic        req = 1'b0;
   logic        we = 1'b0;
   logic [2:0]  addr = '0;
   logic [63:0] wdata = '0;
   logic [7:0]  be = '0;

   logic [2:0]  gnt_w;
   logic [2:0]  rv_w;
   logic [63:0] rd_w [3];

   always #5 clk = ~clk;

   sram_pipe #(
      .DATA_WIDTH(64), .NUM_WORDS(8),
      .READ_LATENCY(1), .CLEAR_ON_RESET(1'b1)
   ) u0 (
      .clk_i(clk), .rst_ni(rst_ni), .req_i(req), .we_i(we),
      .addr_i(addr), .wdata_i(wdata), .be_i(be),
      .gnt_o(gnt_w[0]), .rvalid_o(rv_w[0]), .rdata_o(rd_w[0])
   );

   sram_pipe #(
      .DATA_WIDTH(64), .NUM_WORDS(6),
      .READ_LATENCY(2), .CLEAR_ON_RESET(1'b1)
   ) u1 (
      .clk_i(clk), .rst_ni(rst_ni), .req_i(req), .we_i(we),
      .addr_i(addr), .wdata_i(wdata), .be_i(be),
      .gnt_o(gnt_w[1]), .rvalid_o(rv_w[1]), .rdata_o(rd_w[1])
   );

   sram_pipe #(
      .DATA_WIDTH(64), .NUM_WORDS(5),
      .READ_LATENCY(1), .CLEAR_ON_RESET(1'b0)
   ) u2 (
      .clk_i(clk), .rst_ni(rst_ni), .req_i(req), .we_i(we),
      .addr_i(addr), .wdata_i(wdata), .be_i(be),
      .gnt_o(gnt_w[2]), .rvalid_o(rv_w[2]), .rdata_o(rd_w[2])
   );

   function automatic int nw(int i);
      return (i == 0) ? 8 : (i == 1) ? 6 : 5;
   endfunction

   function automatic int rl(int i);
      return (i == 1) ? 2 : 1;
   endfunction

   function automatic bit clr(int i);
      return i != 2;
   endfunction

   // Model: words, known flags, edges since reset, read schedule by due edge
   logic [63:0] mm [3][8];
   bit          mk [3][8];
   int          cnt [3];
   int          sdue [3][4];
   logic [63:0] sd [3][4];
   bit          sk [3][4];
   logic [63:0] ld [3];
   bit          lk [3];
   int          ec = 0;
   int          rst_ec = 0;
   bit          chk_en = 1'b0;

   int n_tests = 0;
   int n_fail = 0;

   task automatic check(input string nm, input logic [63:0] act,
                        input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   always @(posedge clk) begin
      ec <= ec + 1;
      for (int i = 0; i < 3; i++) begin
         if (!rst_ni) begin
            cnt[i] <= 0;
            rst_ec <= ec + 1;
            for (int s = 0; s < 4; s++) sdue[i][s] <= -1;
         end else if (clr(i) && cnt[i] < nw(i)) begin
            mm[i][cnt[i]] <= '0;
            mk[i][cnt[i]] <= 1'b1;
            cnt[i] <= cnt[i] + 1;
         end else if (req && we) begin
            if (int'(addr) < nw(i)) begin
               for (int b = 0; b < 8; b++)
                  if (be[b]) mm[i][addr][8*b +: 8] <= wdata[8*b +: 8];
               if (be == 8'hFF) mk[i][addr] <= 1'b1;
            end
         end else if (req) begin
            sdue[i][(ec + rl(i)) % 4] <= ec + rl(i);
            sd[i][(ec + rl(i)) % 4] <=
               (int'(addr) < nw(i)) ? mm[i][addr] : 64'h0;
            sk[i][(ec + rl(i)) % 4] <=
               (int'(addr) < nw(i)) ? mk[i][addr] : 1'b1;
         end
      end
   end

   function automatic logic exp_gnt(int i);
      return rst_ni && (!clr(i) || cnt[i] >= nw(i));
   endfunction

   function automatic logic exp_rv(int i);
      return sdue[i][ec % 4] == ec;
   endfunction

   function automatic logic [63:0] exp_d(int i);
      if (exp_rv(i)) return sd[i][ec % 4];
      if (rst_ec == ec) return 64'h0;
      return ld[i];
   endfunction

   function automatic bit exp_k(int i);
      if (exp_rv(i)) return sk[i][ec % 4];
      if (rst_ec == ec) return 1'b1;
      return lk[i];
   endfunction

   always @(negedge clk) begin
      if (chk_en) begin
         for (int i = 0; i < 3; i++) begin
            check($sformatf("gnt[%0d]", i), gnt_w[i], exp_gnt(i));
            check($sformatf("rvalid[%0d]", i), rv_w[i], exp_rv(i));
            if (exp_k(i))
               check($sformatf("rdata[%0d]", i), rd_w[i], exp_d(i));
            ld[i] <= exp_d(i);
            lk[i] <= exp_k(i);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic op(input logic w, input logic [2:0] a,
                     input logic [63:0] d, input logic [7:0] b);
      req = 1'b1;
      we = w;
      addr = a;
      wdata = d;
      be = b;
      tick();
      req = 1'b0;
   endtask

   task automatic clear_len(input int e0, input int e1, input int e2);
      int first [3];
      first = '{-1, -1, -1};
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         for (int i = 0; i < 3; i++)
            if (first[i] < 0 && gnt_w[i]) first[i] = c;
      end
      check("clr_len0", 64'(first[0]), 64'(e0));
      check("clr_len1", 64'(first[1]), 64'(e1));
      check("clr_len2", 64'(first[2]), 64'(e2));
   endtask

   initial begin
      rst_ni = 1'b0;
      tick();
      chk_en = 1'b1;
      tick();
      @(negedge clk);
      check("rst_gnt", 64'(gnt_w[0]), 64'h0);
      check("rst_rvalid", 64'(rv_w[0]), 64'h0);
      check("rst_rdata", rd_w[0], 64'h0);
      tick();
      rst_ni = 1'b1;
      clear_len(8, 6, 0);

      for (int a = 0; a < 8; a++)
         op(1'b1, 3'(a), 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
      rst_ni = 1'b0;
      tick();
      tick();
      rst_ni = 1'b1;
      repeat (10) tick();
      for (int a = 0; a < 8; a++) op(1'b0, 3'(a), '0, '0);
      op(1'b0, 3'd4, '0, '0);
      @(negedge clk);
      check("clr_zero", rd_w[0], 64'h0);
      check("rst_keeps_mem", rd_w[2], 64'hFFFF_FFFF_FFFF_FFFF);

      op(1'b1, 3'd3, 64'h1122_3344_5566_7788, 8'hFF);
      op(1'b1, 3'd3, 64'hAAAA_AAAA_AAAA_AAAA, 8'h0F);
      op(1'b0, 3'd3, '0, '0);
      @(negedge clk);
      check("byte_en", rd_w[0], 64'h1122_3344_AAAA_AAAA);

      op(1'b1, 3'd0, 64'd10, 8'hFF);
      op(1'b1, 3'd1, 64'd11, 8'hFF);
      op(1'b1, 3'd2, 64'd12, 8'hFF);
      op(1'b0, 3'd0, '0, '0);
      @(negedge clk);
      check("lat2_wait", 64'(rv_w[1]), 64'h0);
      op(1'b0, 3'd1, '0, '0);
      @(negedge clk);
      check("lat2_v0", 64'(rv_w[1]), 64'h1);
      check("lat2_d0", rd_w[1], 64'd10);
      op(1'b0, 3'd2, '0, '0);
      @(negedge clk);
      check("lat2_d1", rd_w[1], 64'd11);
      tick();
      @(negedge clk);
      check("lat2_d2", rd_w[1], 64'd12);
      tick();
      @(negedge clk);
      check("lat2_end", 64'(rv_w[1]), 64'h0);
      check("rdata_hold", rd_w[1], 64'd12);

      op(1'b1, 3'd6, 64'h5, 8'hFF);
      op(1'b0, 3'd6, '0, '0);
      @(negedge clk);
      check("raw", rd_w[0], 64'h5);
      op(1'b0, 3'd6, '0, '0);
      op(1'b1, 3'd6, 64'h9, 8'hFF);
      @(negedge clk);
      check("war", rd_w[0], 64'h5);
      op(1'b0, 3'd6, '0, '0);
      @(negedge clk);
      check("war_new", rd_w[0], 64'h9);

      op(1'b1, 3'd7, 64'hDEAD_BEEF_0123_4567, 8'hFF);
      op(1'b0, 3'd7, '0, '0);
      @(negedge clk);
      check("inrange7", rd_w[0], 64'hDEAD_BEEF_0123_4567);
      tick();
      @(negedge clk);
      check("oor_v", 64'(rv_w[1]), 64'h1);
      check("oor_d", rd_w[1], 64'h0);
      for (int a = 0; a < 6; a++) op(1'b0, 3'(a), '0, '0);

      op(1'b0, 3'd0, '0, '0);
      rst_ni = 1'b0;
      tick();
      @(negedge clk);
      check("rst_flush", 64'(rv_w[1]), 64'h0);
      tick();
      rst_ni = 1'b1;
      clear_len(8, 6, 0);

      for (int n = 0; n < 500; n++) begin
         rst_ni = ($urandom_range(0, 149) != 0);
         req = ($urandom_range(0, 3) != 0);
         we = 1'($urandom_range(0, 1));
         addr = 3'($urandom_range(0, 7));
         wdata = {$urandom, $urandom};
         be = 8'($urandom_range(0, 255));
         tick();
      end
      rst_ni = 1'b1;
      req = 1'b0;
      repeat (12) tick();
      @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
